// File: rtl/trigger_bank_pkg.sv
// Shared types, widths and helpers for the trigger bank.
// Optional fire statistics are enabled with TRIGGER_BANK_STATS_EN.
package trigger_bank_pkg;

  localparam int unsigned DELAY_W = 24;
  localparam int unsigned WIDTH_W = 16;
  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SINGLE = 2'd1,
    BURST  = 2'd2,
    TOGGLE = 2'd3
  } mode_t;

  typedef struct packed {
    mode_t              mode;
    logic [DELAY_W-1:0] delay;
    logic [WIDTH_W-1:0] width;
    logic [DELAY_W-1:0] period;
    logic [COUNT_W-1:0] count;
  } cfg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  function automatic logic [WIDTH_W-1:0] eff_width(input logic [WIDTH_W-1:0] w);
    return (w == '0) ? WIDTH_W'(1) : w;
  endfunction

  // Low phase length; a period not longer than the pulse leaves exactly one low cycle.
  function automatic logic [DELAY_W-1:0] low_len(input logic [WIDTH_W-1:0] w_eff,
                                                 input logic [DELAY_W-1:0] period);
    logic [DELAY_W-1:0] w_ext;
    w_ext = DELAY_W'(w_eff);
    return (period <= w_ext) ? DELAY_W'(1) : period - w_ext;
  endfunction

  function automatic logic [COUNT_W-1:0] eff_count(input mode_t m, input logic [COUNT_W-1:0] n);
    return (m == BURST && n != '0) ? n : COUNT_W'(1);
  endfunction

endpackage

// File: rtl/trigger_channel.sv
// One trigger channel: latches its config on an accepted fire and sequences delay/high/low/toggle.
module trigger_channel
  import trigger_bank_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic fire,
  input  cfg_t cfg,
  input  logic clear,
  output logic pulse,
  output logic busy,
  output logic overrun,
  output logic accept_c
);

  state_t             state, state_nx;
  logic [DELAY_W-1:0] cnt, cnt_nx;
  logic [COUNT_W-1:0] pulses, pulses_nx;
  mode_t              mode_q, mode_nx;
  logic [WIDTH_W-1:0] width_q, width_nx;
  logic [DELAY_W-1:0] low_q, low_nx;
  logic               pulse_nx, overrun_nx;
  logic               go_high;
  mode_t              hi_mode;
  logic [WIDTH_W-1:0] hi_width;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      pulses  <= '0;
      mode_q  <= OFF;
      width_q <= '0;
      low_q   <= '0;
      pulse   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pulses  <= pulses_nx;
      mode_q  <= mode_nx;
      width_q <= width_nx;
      low_q   <= low_nx;
      pulse   <= pulse_nx;
      busy    <= (state_nx != IDLE);
      overrun <= overrun_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pulses_nx  = pulses;
    mode_nx    = mode_q;
    width_nx   = width_q;
    low_nx     = low_q;
    pulse_nx   = pulse;
    accept_c   = 1'b0;
    go_high    = 1'b0;
    hi_mode    = mode_q;
    hi_width   = width_q;
    // A fire on a non-idle channel is dropped; set beats clear.
    overrun_nx = (fire && state != IDLE) | (overrun & ~clear);

    case (state)
      IDLE: begin
        if (fire && cfg.mode != OFF) begin
          accept_c  = 1'b1;
          mode_nx   = cfg.mode;
          width_nx  = eff_width(cfg.width);
          low_nx    = low_len(eff_width(cfg.width), cfg.period);
          pulses_nx = eff_count(cfg.mode, cfg.count);
          hi_mode   = cfg.mode;
          hi_width  = eff_width(cfg.width);
          if (cfg.delay == '0) begin
            go_high = 1'b1;
          end else begin
            state_nx = DELAY;
            cnt_nx   = cfg.delay;
          end
        end
      end
      DELAY: begin
        if (cnt <= DELAY_W'(1)) go_high = 1'b1;
        else                    cnt_nx  = cnt - DELAY_W'(1);
      end
      HIGH: begin
        if (cnt > DELAY_W'(1)) begin
          cnt_nx = cnt - DELAY_W'(1);
        end else if (mode_q == TOGGLE) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (pulses > COUNT_W'(1)) begin
          state_nx  = LOW;
          pulse_nx  = 1'b0;
          cnt_nx    = low_q;
          pulses_nx = pulses - COUNT_W'(1);
        end else begin
          state_nx  = IDLE;
          pulse_nx  = 1'b0;
          cnt_nx    = '0;
          pulses_nx = '0;
        end
      end
      LOW: begin
        if (cnt <= DELAY_W'(1)) begin
          state_nx = HIGH;
          pulse_nx = 1'b1;
          cnt_nx   = DELAY_W'(width_q);
        end else begin
          cnt_nx = cnt - DELAY_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    // Toggle mode inverts the held level and spends a single cycle in HIGH.
    if (go_high) begin
      state_nx = HIGH;
      pulse_nx = (hi_mode == TOGGLE) ? ~pulse : 1'b1;
      cnt_nx   = (hi_mode == TOGGLE) ? DELAY_W'(1) : DELAY_W'(hi_width);
    end
  end

endmodule

// File: rtl/trigger_bank.sv
// N-channel programmable trigger bank armed by frame ticks.
// Define TRIGGER_BANK_STATS_EN to add per-channel accepted-fire counters.
module trigger_bank
  import trigger_bank_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    frame_tick_i,
  input  logic [NUM_CHANNELS-1:0] fire_i,
  input  cfg_t [NUM_CHANNELS-1:0] cfg_i,
  input  logic                    clear_i,
  output logic [NUM_CHANNELS-1:0] pulse_o,
  output logic [NUM_CHANNELS-1:0] busy_o,
  output logic [NUM_CHANNELS-1:0] overrun_o
`ifdef TRIGGER_BANK_STATS_EN
  ,
  output logic [31:0]             fire_count_o [NUM_CHANNELS]
`endif
);

  logic [NUM_CHANNELS-1:0] accept;

  for (genvar c = 0; c < int'(NUM_CHANNELS); c++) begin : g_ch
    trigger_channel u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .fire     (frame_tick_i & fire_i[c]),
      .cfg      (cfg_i[c]),
      .clear    (clear_i),
      .pulse    (pulse_o[c]),
      .busy     (busy_o[c]),
      .overrun  (overrun_o[c]),
      .accept_c (accept[c])
    );
  end

`ifdef TRIGGER_BANK_STATS_EN
  // Accepted-fire counters; clear restarts from this cycle's accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < int'(NUM_CHANNELS); c++) fire_count_o[c] <= '0;
    end else begin
      for (int c = 0; c < int'(NUM_CHANNELS); c++)
        fire_count_o[c] <= (clear_i ? 32'd0 : fire_count_o[c]) + 32'(accept[c]);
    end
  end
`else
  logic unused_accept;
  assign unused_accept = ^accept;
`endif

endmodule

// File: tb/tb_trigger_bank.sv
// Self-checking bench for trigger_bank: vector table, scoreboard queue and corner-case sequences.
module tb_trigger_bank;
  import trigger_bank_pkg::*;

  localparam int unsigned NC = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          frame_tick_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [NC-1:0] fire_i = '0;
  cfg_t [NC-1:0] cfg_i;
  logic [NC-1:0] pulse_o, busy_o, overrun_o;
`ifdef TRIGGER_BANK_STATS_EN
  logic [31:0]   fire_count_o [NC];
`endif
  int unsigned   exp_cnt [NC];

  trigger_bank #(.NUM_CHANNELS(NC)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .frame_tick_i (frame_tick_i),
    .fire_i       (fire_i),
    .cfg_i        (cfg_i),
    .clear_i      (clear_i),
    .pulse_o      (pulse_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o)
`ifdef TRIGGER_BANK_STATS_EN
    ,
    .fire_count_o (fire_count_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0] pulse;
    logic [NC-1:0] busy;
  } exp_t;

  typedef struct {
    int    ch;
    mode_t m;
    int    d, w, p, n;
    int    rise;
    int    busy_len;
  } vec_t;

  exp_t          q[$];
  logic [NC-1:0] idle_lvl = '0;
  logic [NC-1:0] exp_ovr = '0;
  int            n_cmp = 0;
  int            n_bad = 0;
  vec_t          tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cfg_t mk(input mode_t m, input int d, input int w, input int p, input int n);
    return '{mode: m, delay: DELAY_W'(d), width: WIDTH_W'(w), period: DELAY_W'(p), count: COUNT_W'(n)};
  endfunction

  // Spec-level waveform: rising edges at 1+d+j*P, each W cycles high, N pulses.
  function automatic void model(input cfg_t c, input int k, input logic lvl,
                                output logic p, output logic b, output int len);
    int d, w, per, n, r;
    d   = int'(c.delay);
    w   = (c.width == 0) ? 1 : int'(c.width);
    per = (int'(c.period) <= w) ? w + 1 : int'(c.period);
    n   = (c.mode == BURST) ? ((c.count == 0) ? 1 : int'(c.count)) : 1;
    if (c.mode == TOGGLE) begin
      p   = (k >= 1 + d) ? ~lvl : lvl;
      b   = (k <= 1 + d);
      len = d + 2;
    end else begin
      r   = k - 1 - d;
      p   = (r >= 0) && (r < (n - 1) * per + w) && ((r % per) < w);
      b   = (k <= d + (n - 1) * per + w);
      len = d + (n - 1) * per + w + 1;
    end
  endfunction

  task automatic push_case(input int ch, input cfg_t c);
    logic p, b;
    int   len, k;
    exp_t e;
    model(c, 1, idle_lvl[ch], p, b, len);
    k = 1;
    while (k <= len || k <= q.size()) begin
      if (k > q.size()) q.push_back('{pulse: idle_lvl, busy: '0});
      model(c, k, idle_lvl[ch], p, b, len);
      e = q[k-1];
      e.pulse[ch] = p;
      e.busy[ch]  = b;
      q[k-1] = e;
      k++;
    end
    if (c.mode == TOGGLE) idle_lvl[ch] = ~idle_lvl[ch];
  endtask

  task automatic randomize_cfg();
    for (int c = 0; c < int'(NC); c++)
      cfg_i[c] = '{mode: mode_t'($urandom_range(3, 0)), delay: DELAY_W'($urandom),
                   width: WIDTH_W'($urandom), period: DELAY_W'($urandom), count: COUNT_W'($urandom)};
  endtask

  task automatic fire(input logic [NC-1:0] mask, input cfg_t [NC-1:0] cv);
    cfg_i        = cv;
    fire_i       = mask;
    frame_tick_i = 1'b1;
    for (int c = 0; c < int'(NC); c++)
      if (mask[c] && cv[c].mode != OFF) begin
        push_case(c, cv[c]);
        exp_cnt[c]++;
      end
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    for (int c = 0; c < int'(NC); c++) exp_cnt[c] = 0;
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) e = q.pop_front();
    else               e = '{pulse: idle_lvl, busy: '0};
    check("pulse_o", 32'(pulse_o), 32'(e.pulse));
    check("busy_o", 32'(busy_o), 32'(e.busy));
    check("overrun_o", 32'(overrun_o), 32'(exp_ovr));
    frame_tick_i = 1'b0;
    fire_i       = '0;
    clear_i      = 1'b0;
    randomize_cfg();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 300) begin
      cyc();
      k++;
    end
    check("drain_budget", 32'(q.size()), 32'd0);
  endtask

  task automatic check_stats();
`ifdef TRIGGER_BANK_STATS_EN
    for (int c = 0; c < int'(NC); c++) check("fire_count_o", fire_count_o[c], 32'(exp_cnt[c]));
`endif
  endtask

  initial begin
    cfg_t [NC-1:0] cv;
    for (int c = 0; c < int'(NC); c++) exp_cnt[c] = 0;
    tbl[0]  = '{0, SINGLE, 5, 3, 0, 0, 6, 8};
    tbl[1]  = '{0, BURST,  0, 2, 5, 3, 1, 12};
    tbl[2]  = '{0, BURST,  1, 4, 2, 2, 2, 10};
    tbl[3]  = '{1, BURST,  0, 0, 0, 3, 1, 5};
    tbl[4]  = '{1, SINGLE, 0, 1, 7, 9, 1, 1};
    tbl[5]  = '{2, BURST,  2, 3, 10, 1, 3, 5};
    tbl[6]  = '{2, BURST,  3, 2, 4, 0, 4, 5};
    tbl[7]  = '{3, OFF,    2, 2, 2, 2, 0, 0};
    tbl[8]  = '{2, TOGGLE, 3, 5, 5, 5, 4, 4};
    tbl[9]  = '{2, TOGGLE, 0, 1, 1, 1, 1, 1};
    tbl[10] = '{3, BURST,  1, 3, 4, 2, 2, 8};
    tbl[11] = '{0, SINGLE, 0, 0, 0, 0, 1, 1};

    randomize_cfg();
    #1 resetn = 1'b0;
    #2;
    check("reset_pulse", 32'(pulse_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_overrun", 32'(overrun_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check_stats();

    // Asynchronous reset in the middle of a HIGH phase.
    cv = cfg_i;
    cv[0] = mk(SINGLE, 0, 10, 0, 0);
    fire(4'b0001, cv);
    repeat (3) cyc();
    #1 resetn = 1'b0;
    #1;
    check("async_reset_pulse", 32'(pulse_o), 32'd0);
    check("async_reset_busy", 32'(busy_o), 32'd0);
    q.delete();
    idle_lvl = '0;
    exp_ovr  = '0;
    for (int c = 0; c < int'(NC); c++) exp_cnt[c] = 0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (12) cyc();
    check_stats();

    // Vector table: one fire per record, then first-edge and busy-length checks.
    for (int i = 0; i < 12; i++) begin
      int          ch, rise, lastb, k;
      logic        lvl;
      logic [NC-1:0] mask;
      ch    = tbl[i].ch;
      cv    = cfg_i;
      cv[ch] = mk(tbl[i].m, tbl[i].d, tbl[i].w, tbl[i].p, tbl[i].n);
      lvl   = idle_lvl[ch];
      mask  = '0;
      mask[ch] = 1'b1;
      fire(mask, cv);
      rise  = 0;
      lastb = 0;
      k     = 0;
      while ((q.size() != 0 || k < 3) && k < 200) begin
        cyc();
        k++;
        if (rise == 0 && pulse_o[ch] !== lvl) rise = k;
        if (busy_o[ch] === 1'b1) lastb = k;
      end
      check("first_edge", 32'(rise), 32'(tbl[i].rise));
      check("busy_len", 32'(lastb), 32'(tbl[i].busy_len));
      check("case_budget", 32'(k < 200), 32'd1);
      check_stats();
    end

    // Fire during DELAY is dropped; clear with a simultaneous new overrun keeps the flag.
    cv = cfg_i;
    cv[1] = mk(SINGLE, 4, 2, 0, 0);
    fire(4'b0010, cv);
    cyc();
    frame_tick_i = 1'b1;
    fire_i       = 4'b0010;
    cfg_i[1]     = mk(SINGLE, 0, 8, 0, 0);
    exp_ovr[1]   = 1'b1;
    cyc();
    do_clear();
    exp_ovr[1] = 1'b0;
    cyc();
    do_clear();
    frame_tick_i = 1'b1;
    fire_i       = 4'b0010;
    exp_ovr[1]   = 1'b1;
    cyc();
    drain();
    do_clear();
    exp_ovr[1] = 1'b0;
    cyc();
    check_stats();

    // Fire in the last busy cycle counts as busy.
    cv = cfg_i;
    cv[1] = mk(SINGLE, 0, 2, 0, 0);
    fire(4'b0010, cv);
    cyc();
    cyc();
    frame_tick_i = 1'b1;
    fire_i       = 4'b0010;
    exp_ovr[1]   = 1'b1;
    repeat (3) cyc();
    check_stats();

    // Simultaneous TOGGLE on ch3 and SINGLE on ch0.
    do_clear();
    exp_ovr = '0;
    cyc();
    cv = cfg_i;
    cv[0] = mk(SINGLE, 2, 3, 0, 0);
    cv[3] = mk(TOGGLE, 4, 0, 0, 0);
    fire(4'b1001, cv);
    drain();
    repeat (3) cyc();
    check("toggle_hold", 32'(pulse_o[3]), 32'd1);
    check_stats();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
